// File: rtl/demux_route_ctrl.sv
// Routes one DW-bit word at a time to one channel (unicast) or to every enabled channel in turn (broadcast).
// Latency: out_valid rises one cycle after acceptance; a unicast word is accepted every 2 cycles at most.
// Backpressure: in_ready is low while a word is in flight. A sink that stalls past TIMEOUT cycles loses its copy and drop pulses.
//
// Ports:
//   clk, rst           clock and asynchronous active-high reset
//   in_valid/in_ready  source handshake; in_data, in_dest, in_bcast and en_mask are captured on acceptance
//   out_valid[7:0]     one-hot valid for the presented channel; out_data is shared by all channels
//   out_ready[7:0]     per-sink ready; only the presented channel's bit is looked at
//   s                  demux select (the presented channel); busy is high outside IDLE
//   drop, drop_cnt     one-cycle pulse per dropped word or skipped channel, and its saturating count
module demux_route_ctrl #(
  parameter int DW      = 8,
  parameter int TIMEOUT = 15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic [2:0]    in_dest,
  input  logic          in_bcast,
  input  logic [7:0]    en_mask,
  output logic [7:0]    out_valid,
  output logic [DW-1:0] out_data,
  input  logic [7:0]    out_ready,
  output logic [2:0]    s,
  output logic          busy,
  output logic          drop,
  output logic [7:0]    drop_cnt
);

  typedef enum logic [1:0] {IDLE, SEND, BCAST} state_t;

  state_t          state_q, state_d;
  logic [2:0]      s_q, s_d;
  logic [DW-1:0]   data_q, data_d;
  logic [7:0]      pend_q, pend_d;
  logic [7:0]      wait_q, wait_d;
  logic            drop_q, drop_d;
  logic [7:0]      drop_cnt_q, drop_cnt_d;

  logic [7:0]      chan_oh;
  logic [7:0]      remaining;
  logic            chan_rdy;
  logic            timed_out;

  // Index of the lowest set bit; broadcast serves channels lowest first.
  function automatic logic [2:0] lowest_idx(input logic [7:0] m);
    logic [2:0] idx;
    idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (m[i]) idx = 3'(i);
    end
    return idx;
  endfunction

  assign chan_oh   = 8'b1 << s_q;
  assign chan_rdy  = |(out_ready & chan_oh);
  assign timed_out = (wait_q == 8'(TIMEOUT));

  always_comb begin
    state_d    = state_q;
    s_d        = s_q;
    data_d     = data_q;
    pend_d     = pend_q;
    wait_d     = wait_q;
    drop_d     = 1'b0;
    remaining  = pend_q & ~chan_oh;

    unique case (state_q)
      IDLE: begin
        // out_data and s only move when a word is actually going to be
        // presented, so a dropped word leaves the visible outputs untouched.
        if (in_valid) begin
          if (in_bcast) begin
            if (en_mask == 8'h00) begin
              drop_d = 1'b1;
            end else begin
              state_d = BCAST;
              pend_d  = en_mask;
              s_d     = lowest_idx(en_mask);
              data_d  = in_data;
              wait_d  = 8'd0;
            end
          end else begin
            if (!en_mask[in_dest]) begin
              drop_d = 1'b1;
            end else begin
              state_d = SEND;
              pend_d  = en_mask;
              s_d     = in_dest;
              data_d  = in_data;
              wait_d  = 8'd0;
            end
          end
        end
      end

      SEND: begin
        if (chan_rdy) begin
          state_d = IDLE;
          pend_d  = 8'h00;
          wait_d  = 8'd0;
        end else if (timed_out) begin
          drop_d  = 1'b1;
          state_d = IDLE;
          pend_d  = 8'h00;
          wait_d  = 8'd0;
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end

      BCAST: begin
        // A channel finishes by delivery or by timeout; either way the next
        // pending channel is presented on the very next cycle.
        if (chan_rdy || timed_out) begin
          drop_d = !chan_rdy;
          pend_d = remaining;
          wait_d = 8'd0;
          if (remaining == 8'h00) begin
            state_d = IDLE;
          end else begin
            s_d = lowest_idx(remaining);
          end
        end else begin
          wait_d = wait_q + 8'd1;
        end
      end

      default: begin
        state_d = IDLE;
        pend_d  = 8'h00;
        wait_d  = 8'd0;
      end
    endcase

    drop_cnt_d = (drop_d && (drop_cnt_q != 8'hFF)) ? drop_cnt_q + 8'd1 : drop_cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      s_q        <= 3'd0;
      data_q     <= '0;
      pend_q     <= 8'h00;
      wait_q     <= 8'd0;
      drop_q     <= 1'b0;
      drop_cnt_q <= 8'h00;
    end else begin
      state_q    <= state_d;
      s_q        <= s_d;
      data_q     <= data_d;
      pend_q     <= pend_d;
      wait_q     <= wait_d;
      drop_q     <= drop_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Outputs decode straight from state registers, so reset clears them
  // without waiting for a clock edge.
  assign busy      = (state_q != IDLE);
  assign in_ready  = (state_q == IDLE) && !rst;
  assign out_valid = busy ? chan_oh : 8'h00;
  assign out_data  = data_q;
  assign s         = s_q;
  assign drop      = drop_q;
  assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_demux_route_ctrl.sv
// Self-checking bench for demux_route_ctrl: a scoreboard queue holds expected deliveries,
// a monitor compares each completed delivery, and per-scenario tasks check timing inline.
module tb_demux_route_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [2:0] in_dest;
  logic       in_bcast;
  logic [7:0] en_mask;
  logic [7:0] out_valid;
  logic [7:0] out_data;
  logic [7:0] out_ready;
  logic [2:0] s;
  logic       busy;
  logic       drop;
  logic [7:0] drop_cnt;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic [7:0] ov;
    logic [2:0] sel;
    logic [7:0] dat;
  } exp_t;

  exp_t sb[$];

  demux_route_ctrl #(.DW(8), .TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_dest(in_dest), .in_bcast(in_bcast), .en_mask(en_mask),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .s(s), .busy(busy), .drop(drop), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  // Delivery monitor: a delivery completes at the next rising edge whenever
  // the presented channel's ready is high; sampled mid-cycle.
  always @(negedge clk) begin
    if (!rst && ((out_valid & out_ready) != 8'h00)) begin
      n_cmp++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL sb_unexpected: got ov=%h s=%0d data=%h, expected no delivery", out_valid, s, out_data);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if ({out_valid, s, out_data} !== {e.ov, e.sel, e.dat}) begin
          n_err++;
          $display("FAIL sb_delivery: got ov=%h s=%0d data=%h, expected ov=%h s=%0d data=%h",
                   out_valid, s, out_data, e.ov, e.sel, e.dat);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Presents one word for exactly one edge; returns at edge+1 of the acceptance edge.
  task automatic present(input logic [7:0] d, input logic [2:0] dst, input logic bc, input logic [7:0] m);
    in_valid = 1'b1;
    in_data  = d;
    in_dest  = dst;
    in_bcast = bc;
    en_mask  = m;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    n_cmp++;
    if ({out_valid, s, out_data, busy, drop, drop_cnt, in_ready} !== {8'h00, 3'd0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0}) begin
      n_err++;
      $display("FAIL reset_state: got ov=%h s=%0d data=%h busy=%b drop=%b cnt=%0d in_ready=%b, expected all zero",
               out_valid, s, out_data, busy, drop, drop_cnt, in_ready);
    end
    tick();
    tick();
    rst = 1'b0;
    tick();
    n_cmp++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_release_in_ready: got %b, expected 1", in_ready);
    end
  endtask

  task automatic test_unicast();
    out_ready = 8'hFF;
    present(8'hA5, 3'd3, 1'b0, 8'hFF);
    sb.push_back('{ov: 8'h08, sel: 3'd3, dat: 8'hA5});
    n_cmp++;
    if ({out_valid, s, out_data, busy} !== {8'h08, 3'd3, 8'hA5, 1'b1}) begin
      n_err++;
      $display("FAIL unicast_present: got ov=%h s=%0d data=%h busy=%b, expected ov=08 s=3 data=a5 busy=1",
               out_valid, s, out_data, busy);
    end
    tick();
    n_cmp++;
    if ({in_ready, out_valid, drop, out_data, s} !== {1'b1, 8'h00, 1'b0, 8'hA5, 3'd3}) begin
      n_err++;
      $display("FAIL unicast_done: got in_ready=%b ov=%h drop=%b data=%h s=%0d, expected 1 00 0 a5 3",
               in_ready, out_valid, drop, out_data, s);
    end
  endtask

  task automatic test_bcast();
    logic [7:0] exp_ov [3];
    logic [2:0] exp_s  [3];
    exp_ov = '{8'h01, 8'h08, 8'h20};
    exp_s  = '{3'd0, 3'd3, 3'd5};
    out_ready = 8'hFF;
    present(8'h3C, 3'd6, 1'b1, 8'h29);
    // The captured mask must govern the broadcast, not the live input.
    en_mask = 8'h00;
    for (int i = 0; i < 3; i++) sb.push_back('{ov: exp_ov[i], sel: exp_s[i], dat: 8'h3C});
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if ({out_valid, s, busy} !== {exp_ov[i], exp_s[i], 1'b1}) begin
        n_err++;
        $display("FAIL bcast_step%0d: got ov=%h s=%0d busy=%b, expected ov=%h s=%0d busy=1",
                 i, out_valid, s, busy, exp_ov[i], exp_s[i]);
      end
      tick();
    end
    n_cmp++;
    if ({busy, out_valid, drop, drop_cnt} !== {1'b0, 8'h00, 1'b0, 8'h00}) begin
      n_err++;
      $display("FAIL bcast_end: got busy=%b ov=%h drop=%b cnt=%0d, expected 0 00 0 0",
               busy, out_valid, drop, drop_cnt);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    logic [2:0] dst;
    out_ready = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      d   = 8'(8'h10 + 8'(i * 17));
      dst = 3'(7 - i);
      n_cmp++;
      if (in_ready !== 1'b1) begin
        n_err++;
        $display("FAIL b2b_ready%0d: got in_ready=%b, expected 1", i, in_ready);
      end
      sb.push_back('{ov: 8'b1 << dst, sel: dst, dat: d});
      present(d, dst, 1'b0, 8'hFF);
      tick();
    end
  endtask

  task automatic test_timeout();
    int ov6_cycles;
    int drop_pulses;
    ov6_cycles  = 0;
    drop_pulses = 0;
    // Only channel 6 is stalled; every other ready bit is high and must be ignored.
    out_ready = 8'hBF;
    present(8'h77, 3'd6, 1'b0, 8'hFF);
    for (int i = 0; i < 40; i++) begin
      if (out_valid[6]) ov6_cycles++;
      if (drop) drop_pulses++;
      tick();
    end
    n_cmp++;
    if (ov6_cycles != 16) begin
      n_err++;
      $display("FAIL timeout_ov_cycles: got %0d, expected 16", ov6_cycles);
    end
    n_cmp++;
    if ({drop_pulses[7:0], drop_cnt, busy} !== {8'd1, 8'd1, 1'b0}) begin
      n_err++;
      $display("FAIL timeout_drop: got pulses=%0d cnt=%0d busy=%b, expected 1 1 0", drop_pulses, drop_cnt, busy);
    end
  endtask

  task automatic test_disabled();
    do_reset();
    out_ready = 8'hFF;
    present(8'h11, 3'd0, 1'b0, 8'hFE);
    n_cmp++;
    if ({drop, drop_cnt, out_valid, busy, in_ready} !== {1'b1, 8'd1, 8'h00, 1'b0, 1'b1}) begin
      n_err++;
      $display("FAIL disabled_uni: got drop=%b cnt=%0d ov=%h busy=%b in_ready=%b, expected 1 1 00 0 1",
               drop, drop_cnt, out_valid, busy, in_ready);
    end
    tick();
    n_cmp++;
    if (drop !== 1'b0) begin
      n_err++;
      $display("FAIL disabled_pulse_width: got drop=%b, expected 0", drop);
    end
    present(8'h22, 3'd4, 1'b1, 8'h00);
    n_cmp++;
    if ({drop, drop_cnt, out_valid, busy} !== {1'b1, 8'd2, 8'h00, 1'b0}) begin
      n_err++;
      $display("FAIL disabled_bcast: got drop=%b cnt=%0d ov=%h busy=%b, expected 1 2 00 0",
               drop, drop_cnt, out_valid, busy);
    end
    tick();
  endtask

  task automatic test_reset_mid_bcast();
    out_ready = 8'h00;
    present(8'h99, 3'd0, 1'b1, 8'h0C);
    tick();
    n_cmp++;
    if ({out_valid, s, busy} !== {8'h04, 3'd2, 1'b1}) begin
      n_err++;
      $display("FAIL midrst_serving: got ov=%h s=%0d busy=%b, expected 04 2 1", out_valid, s, busy);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({out_valid, busy, drop_cnt, drop, in_ready} !== {8'h00, 1'b0, 8'h00, 1'b0, 1'b0}) begin
      n_err++;
      $display("FAIL midrst_async: got ov=%h busy=%b cnt=%0d drop=%b in_ready=%b, expected 00 0 0 0 0",
               out_valid, busy, drop_cnt, drop, in_ready);
    end
    tick();
    rst = 1'b0;
    out_ready = 8'hFF;
    tick();
    sb.push_back('{ov: 8'h80, sel: 3'd7, dat: 8'h5A});
    present(8'h5A, 3'd7, 1'b0, 8'hFF);
    n_cmp++;
    if ({out_valid, s, out_data} !== {8'h80, 3'd7, 8'h5A}) begin
      n_err++;
      $display("FAIL midrst_uni7: got ov=%h s=%0d data=%h, expected 80 7 5a", out_valid, s, out_data);
    end
    tick();
    n_cmp++;
    if ({busy, drop, drop_cnt} !== {1'b0, 1'b0, 8'h00}) begin
      n_err++;
      $display("FAIL midrst_after: got busy=%b drop=%b cnt=%0d, expected 0 0 0", busy, drop, drop_cnt);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    in_valid = 1'b1;
    in_bcast = 1'b0;
    in_dest  = 3'd1;
    en_mask  = 8'h00;
    for (int k = 1; k <= 300; k++) begin
      tick();
      if (k == 254 || k == 255 || k == 300) begin
        n_cmp++;
        if (drop_cnt !== ((k < 255) ? 8'(k) : 8'd255)) begin
          n_err++;
          $display("FAIL sat_cnt_after_%0d: got %0d, expected %0d", k, drop_cnt, (k < 255) ? k : 255);
        end
      end
    end
    in_valid = 1'b0;
    tick();
    tick();
    n_cmp++;
    if ({drop_cnt, drop} !== {8'd255, 1'b0}) begin
      n_err++;
      $display("FAIL sat_hold: got cnt=%0d drop=%b, expected 255 0", drop_cnt, drop);
    end
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 8'h00;
    in_dest   = 3'd0;
    in_bcast  = 1'b0;
    en_mask   = 8'h00;
    out_ready = 8'h00;

    test_reset();
    test_unicast();
    test_bcast();
    test_back_to_back();
    test_timeout();
    test_disabled();
    test_reset_mid_bcast();
    test_saturation();

    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL sb_leftover: got %0d undelivered, expected 0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
